alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
// Execution ALU driven by the 4-bit operation code produced by the ALU control decoder.
// Registers one operation per start pulse. Logic/arith/shift/compare ops complete in 1 cycle.
// DIV runs as an iterative unsigned restoring divider (one quotient bit per cycle).
// Sits between the register-file read ports and the write-back mux; busy stalls the datapath.
// PARAMETERS
// W       32   operand/result width (>=8; DIV iteration count equals W)
// OPW     4    operation code width (fixed by ALU control encoding)
// PORTS
// clk     in   1    rising-edge clock
// rst_n   in   1    asynchronous active-low reset
// start   in   1    request; accepted only when busy==0
// ops     in   4    operation code, sampled with start
// a       in   W    operand A (rs), sampled with start
// b       in   W    operand B (rt; shift amount in b[4:0]), sampled with start
// busy    out  1    1 while a DIV is iterating; start ignored
// done    out  1    1-cycle pulse: result/rem/zero/ovf valid this cycle
// result  out  W    registered result (quotient for DIV)
// rem     out  W    remainder for DIV; 0 for all other ops
// zero    out  1    result==0, valid with done
// ovf     out  1    signed overflow for ADD/SUB; 0 otherwise
// BEHAVIOUR
// - Clock: one clock, clk. Reset: asynchronous, active-low, rst_n.
// - Reset: busy=0, done=0, result=0, rem=0, zero=0, ovf=0; FSM->IDLE; iteration counter=0.
// - Op codes: 0000 AND, 0001 OR, 0010 ADD, 0100 NOR, 0110 SUB, 0101 SRL (a>>b[4:0]),
//   1000 DIV (unsigned), 1001 SLT (signed, result=1/0), 1111 NOP (result=0); any other -> NOP.
// - FSM states: IDLE, DIV_RUN, DIV_DONE.
// - IDLE, start=1, non-DIV op: outputs registered at next edge; done=1 the cycle after start.
//   Latency 1; back-to-back starts allowed every cycle.
// - IDLE, start=1, ops=1000, b!=0: latch a,b; busy=1 from next cycle; enter DIV_RUN.
// - DIV_RUN: W iterations, one quotient bit per cycle; counter W-1 down to 0.
// - DIV_RUN: counter==0 -> DIV_DONE.
// - DIV_DONE: done=1, busy=0, result=quotient, rem=remainder; return to IDLE.
//   A start in DIV_DONE is ignored. DIV latency = W+1 cycles from start to done.
// - DIV by zero (b==0): no iteration; 1-cycle path; result={W{1}}, rem=a, ovf=0.
// - start while busy: ignored, no state change; the caller holds start until it is accepted.
// - ADD/SUB width: W-bit wrap-around. ovf = operand signs equal (SUB: a vs ~b) and result sign differs.
// - zero computed from the registered result in every completing op, including NOP (zero=1).
// - done deasserts the cycle after its pulse unless a new single-cycle op completes.
// - rst_n low mid-DIV: immediate abort; all outputs to reset values; no done emitted.
// STRUCTURE
// - Shared package alu_pkg: localparams OP_AND=4'b0000, OP_OR=4'b0001, OP_ADD=4'b0010,
//   OP_NOR=4'b0100, OP_SRL=4'b0101, OP_SUB=4'b0110, OP_DIV=4'b1000, OP_SLT=4'b1001,
//   OP_NOP=4'b1111; FSM state encodings.
//   The ALU control decoder imports the same op constants.
// - One sub-module: alu_div_seq (restoring divider datapath: partial remainder, quotient shift,
//   counter). The FSM and the single-cycle ops stay in alu_exec.
// TESTING
// 1 Reset: rst_n=0 with start=1 -> all outputs 0, busy=0; release -> first op accepted normally.
// 2 Single-cycle ops: a=0x0000000F, b=0x000000F0, ADD -> result 0xFF, done next cycle.
//   Same a, b with AND -> result 0, zero=1.
//   SUB 5-7 -> 0xFFFFFFFE. SLT -3<2 -> 1. SRL 0x80000000>>31 -> 1.
//   NOR 0,0 -> 0xFFFFFFFF. Op 0011 -> result 0.
// 3 Overflow: ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//   SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
//   ADD 1+1 -> ovf=0.
// 4 DIV: 100/7 -> busy for W cycles, done at cycle W+1, result=14, rem=2.
//   Starts while busy are ignored; next op is accepted the cycle after done.
// 5 DIV by zero: 0x1234/0 -> done after 1 cycle, result=0xFFFFFFFF, rem=0x1234, busy never set.
// 6 Reset mid-DIV: rst_n=0 at iteration 10 -> busy=0, no done.
//   A fresh ADD after release completes in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU operation codes and execution-unit FSM encoding.
// Shared by alu_exec and the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_RUN  = 2'd1,
    S_DIV_DONE = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Unsigned restoring divider datapath: one quotient bit per step.
// Exposes the post-step quotient/remainder so the final step can be captured.
module alu_div_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_last,
  output logic [W-1:0] o_quo_nxt,
  output logic [W-1:0] o_rem_nxt
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;

  logic [W:0] w_sh;
  logic [W:0] w_diff;
  logic       w_ge;

  // Partial remainder stays below the divisor, so bit W of the
  // difference is a clean borrow flag.
  assign w_sh      = {r_rem, r_quo[W-1]};
  assign w_diff    = w_sh - {1'b0, r_div};
  assign w_ge      = ~w_diff[W];
  assign o_rem_nxt = w_ge ? w_diff[W-1:0] : w_sh[W-1:0];
  assign o_quo_nxt = {r_quo[W-2:0], w_ge};
  assign o_last    = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_a;
      r_div <= i_b;
      r_cnt <= CW'(W - 1);
    end else if (i_step) begin
      r_rem <= o_rem_nxt;
      r_quo <= o_quo_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execution ALU: single-cycle logic/arith/shift/compare ops
// plus an iterative unsigned divider that stalls via busy.
module alu_exec #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] ops,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic [W-1:0]   rem,
  output logic           zero,
  output logic           ovf
);

  import alu_pkg::*;

  exec_state_e r_state;
  exec_state_e w_state_nxt;

  logic [W-1:0] r_result;
  logic [W-1:0] r_rem;
  logic         r_done;
  logic         r_zero;
  logic         r_ovf;

  logic [W-1:0] w_sum;
  logic [W-1:0] w_dif;
  logic [W-1:0] w_res;
  logic         w_ovf;
  logic         w_accept;
  logic         w_is_div;
  logic         w_div_go;
  logic         w_div_step;
  logic         w_last;
  logic [W-1:0] w_quo_nxt;
  logic [W-1:0] w_rem_nxt;

  assign w_accept   = start && (r_state == S_IDLE);
  assign w_is_div   = (ops == OP_DIV);
  assign w_div_go   = w_accept && w_is_div && (b != '0);
  assign w_div_step = (r_state == S_DIV_RUN);

  assign w_sum = a + b;
  assign w_dif = a - b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ops)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_NOR: w_res = ~(a | b);
      OP_SRL: w_res = a >> b[4:0];
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (a[W-1] == ~b[W-1]) && (w_dif[W-1] != a[W-1]);
      end
      OP_SLT: w_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      default: w_res = '0;
    endcase
  end

  alu_div_seq #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_div_go),
    .i_step    (w_div_step),
    .i_a       (a),
    .i_b       (b),
    .o_last    (w_last),
    .o_quo_nxt (w_quo_nxt),
    .o_rem_nxt (w_rem_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (w_div_go) w_state_nxt = S_DIV_RUN;
      S_DIV_RUN:  if (w_last)   w_state_nxt = S_DIV_DONE;
      S_DIV_DONE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_rem    <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && !w_div_go) begin
        r_done <= 1'b1;
        if (w_is_div) begin
          // divide by zero: all-ones quotient, dividend as remainder
          r_result <= '1;
          r_rem    <= a;
          r_zero   <= 1'b0;
          r_ovf    <= 1'b0;
        end else begin
          r_result <= w_res;
          r_rem    <= '0;
          r_zero   <= (w_res == '0);
          r_ovf    <= w_ovf;
        end
      end else if (w_div_step && w_last) begin
        r_done   <= 1'b1;
        r_result <= w_quo_nxt;
        r_rem    <= w_rem_nxt;
        r_zero   <= (w_quo_nxt == '0);
        r_ovf    <= 1'b0;
      end
    end
  end

  assign busy   = (r_state == S_DIV_RUN);
  assign done   = r_done;
  assign result = r_result;
  assign rem    = r_rem;
  assign zero   = r_zero;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table for single-cycle ops,
// hand sequences for DIV, divide-by-zero and reset mid-DIV.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   ops;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] rem;
  logic         zero;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec #(.W(W), .OPW(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ops    (ops),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rem    (rem),
    .zero   (zero),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] res;
    logic         z;
    logic         o;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic d,
                            input logic bz, input logic [W-1:0] r,
                            input logic [W-1:0] rm, input logic z,
                            input logic o);
    check({name, ".done"}, {31'd0, done}, {31'd0, d});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, bz});
    check({name, ".result"}, result, r);
    check({name, ".rem"}, rem, rm);
    check({name, ".zero"}, {31'd0, zero}, {31'd0, z});
    check({name, ".ovf"}, {31'd0, ovf}, {31'd0, o});
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 32'h0000000F, 32'h000000F0, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3]  = '{4'b1001, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 1'b0, 1'b0};
    vecs[4]  = '{4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0};
    vecs[5]  = '{4'b0100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6]  = '{4'b0011, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[8]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[9]  = '{4'b0010, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0};
    vecs[10] = '{4'b0001, 32'h000000A0, 32'h0000000B, 32'h000000AB, 1'b0, 1'b0};
    vecs[11] = '{4'b1111, 32'h000000FF, 32'h000000FF, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{4'b1001, 32'h00000002, 32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{4'b0101, 32'h000000F0, 32'h00000024, 32'h0000000F, 1'b0, 1'b0};
    vecs[14] = '{4'b0110, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1};

    // reset with start held high
    rst_n = 1'b0;
    start = 1'b1;
    ops   = 4'b0010;
    a     = 32'd1;
    b     = 32'd1;
    repeat (3) @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("first_op", 1'b1, 1'b0, 32'd2, '0, 1'b0, 1'b0);

    // back-to-back single-cycle ops
    for (int i = 0; i < 15; i++) begin
      ops = vecs[i].op;
      a   = vecs[i].va;
      b   = vecs[i].vb;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), 1'b1, 1'b0, vecs[i].res, '0,
                 vecs[i].z, vecs[i].o);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_drop", {31'd0, done}, 32'd0);

    // DIV 100/7 while a pending ADD is held on start
    start = 1'b1;
    ops   = 4'b1000;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    ops = 4'b0010;
    a   = 32'd3;
    b   = 32'd4;
    begin
      int bad = 0;
      for (int n = 1; n <= W; n++) begin
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        @(negedge clk);
      end
      check("div_busy_window", bad, 0);
    end
    check_outs("div_done", 1'b1, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("div_after", 1'b0, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("add_after_div", 1'b1, 1'b0, 32'd7, '0, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);

    // divide by zero
    start = 1'b1;
    ops   = 4'b1000;
    a     = 32'h1234;
    b     = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check_outs("div0", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b0, 1'b0);
    @(negedge clk);
    check("div0_busy", {31'd0, busy}, 32'd0);
    check("div0_done_drop", {31'd0, done}, 32'd0);

    // reset mid-DIV
    start = 1'b1;
    ops   = 4'b1000;
    a     = 32'h0000FFFF;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_outs("mid_reset", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int n = 0; n < W + 4; n++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      check("no_done_after_abort", seen, 0);
    end
    start = 1'b1;
    ops   = 4'b0010;
    a     = 32'd20;
    b     = 32'd22;
    @(negedge clk);
    start = 1'b0;
    check_outs("add_after_abort", 1'b1, 1'b0, 32'd42, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
